// File: rtl/microseq_control_unit.sv
// microseq_control_unit: instruction-cycle sequencer driving a 16-bit datapath control word
// Ports:
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   start                    level; leaves IDLE, HALT and FAULT
//   ir_opcode [OPCODE_W]     opcode field from IR, stable from DECODE onward
//   z_flag                   AC==0 flag, sampled in DECODE for JMPZ
//   mem_ready                memory finishes the current access this cycle
//   control_out [16]         {branch, pc_inc, bus_sel[3:0], ld_ar, ld_ir, ld_dr, ld_r, ld_pc, ld_ac, mem_op[1:0], alu_op[1:0]}
//   state_out [6]            current state code
//   busy                     not in IDLE, HALT or FAULT
//   illegal_op               one-cycle pulse after decoding an undefined opcode
//   fault                    sticky memory-timeout flag, cleared when leaving FAULT
module microseq_control_unit #(
    parameter int OPCODE_W    = 8,
    parameter int WAIT_EN     = 1,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic                z_flag,
    input  logic                mem_ready,
    output logic [15:0]         control_out,
    output logic [5:0]          state_out,
    output logic                busy,
    output logic                illegal_op,
    output logic                fault
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [5:0] {
        IDLE   = 6'd0,  FETCH1 = 6'd1,  FETCH2 = 6'd2,  FETCH3 = 6'd3,  DECODE = 6'd4,
        CLAC   = 6'd5,  LDAC1  = 6'd6,  LDAC2  = 6'd7,  LDAC3  = 6'd8,  LDAC4  = 6'd9,
        LDAC5  = 6'd10, STAC1  = 6'd11, STAC2  = 6'd12, STAC3  = 6'd13, STAC4  = 6'd14,
        MVACR  = 6'd15, MVRAC  = 6'd16, ADD    = 6'd17, MUL    = 6'd18, JMP1   = 6'd19,
        JMP2   = 6'd20, JMP3   = 6'd21, JSKIP  = 6'd22, HALT   = 6'd23, FAULT  = 6'd24
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [15:0]   word;
    logic [31:0]   op;
    logic          mem_state;
    logic          stall;
    logic          timeout;

    assign op        = 32'(ir_opcode);
    assign mem_state = state inside {FETCH2, LDAC2, LDAC4, STAC2, STAC4, JMP2};
    assign stall     = (WAIT_EN != 0) && mem_state && !mem_ready;
    // the stall that would make the count reach TIMEOUT_CYC ends the access in FAULT
    assign timeout   = stall && (wait_cnt == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        word = 16'h0000;
        case (state)
            FETCH1, LDAC1, STAC1, JMP1: word = 16'h0600;
            FETCH2, LDAC2, STAC2:       word = 16'h5484;
            FETCH3:                     word = 16'h0900;
            CLAC:                       word = 16'h0013;
            LDAC3, STAC3:               word = 16'h0A00;
            LDAC4, JMP2:                word = 16'h1484;
            LDAC5:                      word = 16'h0810;
            STAC4:                      word = 16'h1008;
            MVACR:                      word = 16'h1040;
            MVRAC:                      word = 16'h0C10;
            ADD:                        word = 16'h0C11;
            MUL:                        word = 16'h0C12;
            JMP3:                       word = 16'h8820;
            JSKIP:                      word = 16'h4000;
            default:                    word = 16'h0000;
        endcase
    end

    // pc_inc only on the cycle the access completes, so PC moves once per access
    assign control_out = {word[15], word[14] & (mem_ready | (WAIT_EN == 0)), word[13:0]};
    assign state_out   = state;
    assign busy        = !(state inside {IDLE, HALT, FAULT});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            fault      <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= 1'b0;
            if (stall) begin
                if (timeout) begin
                    state    <= FAULT;
                    fault    <= 1'b1;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
            end else begin
                wait_cnt <= '0;
                case (state)
                    IDLE, HALT: if (start) state <= FETCH1;
                    FAULT: if (start) begin
                        state <= FETCH1;
                        fault <= 1'b0;
                    end
                    FETCH1, FETCH2, FETCH3, LDAC1, LDAC2, LDAC3, LDAC4,
                    STAC1, STAC2, STAC3, JMP1, JMP2: state <= state_t'(state + 6'd1);
                    CLAC, LDAC5, STAC4, MVACR, MVRAC, ADD, MUL, JMP3, JSKIP: state <= FETCH1;
                    DECODE: case (op)
                        32'd0:   state <= FETCH1;
                        32'd1:   state <= CLAC;
                        32'd2:   state <= LDAC1;
                        32'd3:   state <= STAC1;
                        32'd4:   state <= MVACR;
                        32'd5:   state <= MVRAC;
                        32'd6:   state <= ADD;
                        32'd7:   state <= MUL;
                        32'd8:   state <= JMP1;
                        32'd9:   state <= z_flag ? JMP1 : JSKIP;
                        32'd10:  state <= HALT;
                        default: begin
                            state      <= FETCH1;
                            illegal_op <= 1'b1;
                        end
                    endcase
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
